// File: rtl/seg_hc595_pkg.sv
// Shared constants for the 74HC595 seven-segment scanner: hex glyph table,
// segment-byte bit positions and the shifter state encoding.
package seg_hc595_pkg;

    localparam int SEG_W  = 8;
    localparam int SEG_DP = 7;

    // Segment order g..a in bits [6:0], active-high.
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble + decimal point + blank to active-high segment byte.
module hex_to_seg
    import seg_hc595_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             dp,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    // NOTE: every output gets a default before the conditional, so no latch is inferred.
    always_comb begin
        seg = '0;
        if (!blank) begin
            seg[SEG_DP] = dp;
            seg[6:0]    = HEX_TABLE[nibble];
        end
    end

endmodule

// File: rtl/seg_hc595_scanner.sv
// Multiplexed 7-segment scanner driving a daisy-chained 74HC595 pair (DIO/SRCLK/RCLK).
// Optional leading-zero blanking is enabled by defining SEG_HC595_LZB_EN.
module seg_hc595_scanner
    import seg_hc595_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int SRCLK_DIV   = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [4*DIGITS-1:0]   Disp_Data,
    input  logic [DIGITS-1:0]     Dp,
    input  logic [DIGITS-1:0]     Blank,
    input  logic                  Load,
    output logic                  DIO,
    output logic                  SRCLK,
    output logic                  RCLK,
    output logic                  Frame_Done
);

    localparam int TICK   = CLK_HZ / SCAN_HZ;
    localparam int WORD_W = 8 + DIGITS;
    localparam int TICK_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W  = (SRCLK_DIV > 1) ? $clog2(SRCLK_DIV) : 1;
    localparam int BIT_W  = $clog2(WORD_W);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SRCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);

    // A whole digit (build, shift, latch) must finish before the next scan tick.
    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("seg_hc595_scanner: DIGITS must be 1..8");
        end
        if (SRCLK_DIV < 1 || (WORD_W * 2 * SRCLK_DIV + 2 * SRCLK_DIV) >= TICK) begin : g_bad_timing
            $error("seg_hc595_scanner: digit shift does not fit in one scan tick");
        end
    endgenerate

    state_t               state;
    logic [TICK_W-1:0]    tick_cnt;
    logic                 scan_tick;
    logic [IDX_W-1:0]     idx;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WORD_W-2:0]    word_q;

    logic [4*DIGITS-1:0]  pend_data, shadow_data, src_data;
    logic [DIGITS-1:0]    pend_dp, shadow_dp, src_dp;
    logic [DIGITS-1:0]    pend_blank, shadow_blank, src_blank, blank_eff;
    logic                 pend_flag;
    logic                 apply;

    logic [3:0]           cur_nib;
    logic [SEG_W-1:0]     seg_act;
    logic [DIGITS-1:0]    sel_act;
    logic [WORD_W-1:0]    word;

    // NOTE: asynchronous active-low reset; every state register, including the
    // pending/shadow data, is cleared so the first frame after reset is defined.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign scan_tick = (tick_cnt == TICK_LAST);
    assign apply     = (state == ST_BUILD) && (idx == '0);

    // Pending data only reaches the shadow at the start of a frame; a Load in
    // that same cycle bypasses the pending register.
    always_comb begin
        src_data  = shadow_data;
        src_dp    = shadow_dp;
        src_blank = shadow_blank;
        if (apply) begin
            if (Load) begin
                src_data  = Disp_Data;
                src_dp    = Dp;
                src_blank = Blank;
            end else if (pend_flag) begin
                src_data  = pend_data;
                src_dp    = pend_dp;
                src_blank = pend_blank;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_data    <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            pend_flag    <= 1'b0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
        end else if (apply) begin
            shadow_data  <= src_data;
            shadow_dp    <= src_dp;
            shadow_blank <= src_blank;
            pend_flag    <= 1'b0;
        end else if (Load) begin
            pend_data    <= Disp_Data;
            pend_dp      <= Dp;
            pend_blank   <= Blank;
            pend_flag    <= 1'b1;
        end
    end

`ifdef SEG_HC595_LZB_EN
    logic higher_zero;

    always_comb begin
        blank_eff   = src_blank;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero && (src_data[4*i +: 4] == 4'h0);
            if (higher_zero && !src_dp[i]) begin
                blank_eff[i] = 1'b1;
            end
        end
    end
`else
    assign blank_eff = src_blank;
`endif

    assign cur_nib = src_data[4*idx +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .dp     (src_dp[idx]),
        .blank  (blank_eff[idx]),
        .seg    (seg_act)
    );

    always_comb begin
        sel_act      = '0;
        sel_act[idx] = 1'b1;
    end

    assign word = {(SEL_ACT_LOW ? ~sel_act : sel_act), (SEG_ACT_LOW ? ~seg_act : seg_act)};

    // word_q holds the bits still to be sent after the one currently on DIO.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            word_q     <= '0;
            DIO        <= 1'b0;
            SRCLK      <= 1'b0;
            RCLK       <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scan_tick) state <= ST_BUILD;
                end
                ST_BUILD: begin
                    DIO     <= word[WORD_W-1];
                    word_q  <= word[WORD_W-2:0];
                    SRCLK   <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        SRCLK   <= 1'b1;
                        state   <= ST_SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        SRCLK   <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            RCLK  <= 1'b1;
                            state <= ST_LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            DIO     <= word_q[WORD_W-2];
                            word_q  <= {word_q[WORD_W-3:0], 1'b0};
                            state   <= ST_SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        RCLK    <= 1'b0;
                        state   <= ST_IDLE;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            Frame_Done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_hc595_scanner.sv
// Self-checking bench: models the 595 chain from the serial pins and compares
// latched words against a behavioural display model.
module tb_seg_hc595_scanner;

    localparam int DIGITS = 8;
    localparam int DIV    = 2;
    localparam int TICK   = 100;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] Disp_Data = '0;
    logic [7:0]  Dp = '0;
    logic [7:0]  Blank = '0;
    logic        Load = 1'b0;
    logic        DIO, SRCLK, RCLK, Frame_Done;

    int checks = 0;
    int failures = 0;

    seg_hc595_scanner #(
        .DIGITS(DIGITS), .CLK_HZ(100000), .SCAN_HZ(1000), .SRCLK_DIV(DIV),
        .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Disp_Data(Disp_Data), .Dp(Dp), .Blank(Blank),
        .Load(Load), .DIO(DIO), .SRCLK(SRCLK), .RCLK(RCLK), .Frame_Done(Frame_Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // 595 chain: shift register clocked by SRCLK.
    logic [15:0] sreg = '0;
    always @(posedge SRCLK) sreg <= {sreg[14:0], DIO};

    // Pin monitor: storage latch capture plus protocol rules.
    logic [15:0] lat_q[$];
    int lat_total = 0, since_fd = 0, viol = 0, fd_viol = 0;
    int stable = 0, rclk_run = 0, cyc = 0, last_rclk = 0, rclk_gap = 0;
    logic prev_dio = 0, prev_srclk = 0, prev_rclk = 0;

    always @(negedge Clk) begin
        cyc++;
        if (!Reset_n) begin
            since_fd = 0; stable = 0; rclk_run = 0;
            prev_dio = 0; prev_srclk = 0; prev_rclk = 0;
        end else begin
            if (SRCLK && RCLK) viol++;
            if (SRCLK && DIO != prev_dio) viol++;
            stable = (DIO == prev_dio) ? stable + 1 : 1;
            if (SRCLK && !prev_srclk && stable < DIV + 1) viol++;
            if (RCLK) rclk_run++;
            if (!RCLK && prev_rclk) begin
                if (rclk_run != DIV) viol++;
                rclk_run = 0;
            end
            if (RCLK && !prev_rclk) begin
                lat_q.push_back(sreg);
                lat_total++;
                since_fd++;
                rclk_gap = cyc - last_rclk;
                last_rclk = cyc;
            end
            if (Frame_Done) begin
                if (since_fd != DIGITS || lat_q[$][15:8] != 8'h80) fd_viol++;
                since_fd = 0;
            end
            prev_dio = DIO; prev_srclk = SRCLK; prev_rclk = RCLK;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Expected 16-bit word for digit d: one-hot select over inverted segments.
    function automatic logic [15:0] exp_word(input logic [31:0] data, input logic [7:0] dp,
                                             input logic [7:0] blank, input int d);
        logic [7:0] seg, sel;
        logic dark;
        dark = blank[d];
`ifdef SEG_HC595_LZB_EN
        if (d > 0 && !dp[d] && (data >> (4 * d)) == 32'd0) dark = 1'b1;
`endif
        seg = dark ? 8'h00 : {dp[d], hex7(data[4*d +: 4])};
        sel = 8'h01 << d;
        return {sel, ~seg};
    endfunction

    task automatic do_load(input logic [31:0] data, input logic [7:0] dp, input logic [7:0] blank);
        @(negedge Clk);
        Disp_Data = data; Dp = dp; Blank = blank; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge Clk);
            if (Frame_Done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_lat(input int count, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge Clk);
            if (lat_q.size() >= count) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Finish the frame in flight, then capture the next full frame.
    task automatic get_frame(output int base);
        bit ok;
        wait_fd(ok);
        check("frame_done_wait", 32'(ok), 32'd1);
        base = lat_q.size();
        wait_fd(ok);
        check("frame_done_wait", 32'(ok), 32'd1);
        check("frame_len", 32'(lat_q.size() - base), 32'd8);
    endtask

    task automatic check_frame(input string name, input int base, input logic [31:0] data,
                               input logic [7:0] dp, input logic [7:0] blank, input int first);
        for (int k = first; k < DIGITS; k++) begin
            if (base + k < lat_q.size())
                check(name, 32'(lat_q[base + k]), 32'(exp_word(data, dp, blank, k)));
            else
                check(name, 32'hDEAD, 32'(exp_word(data, dp, blank, k)));
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        int          digit;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int base, pre;
        bit ok;
        logic [31:0] rd;
        logic [7:0] rdp, rbl;

        vecs[0] = '{32'h1234_5678, 8'h00, 8'h00, 0, 16'h0180};
        vecs[1] = '{32'h1234_5678, 8'h00, 8'h00, 7, 16'h80F9};
        vecs[2] = '{32'h1234_5678, 8'h01, 8'h00, 0, 16'h0100};
        vecs[3] = '{32'h1234_5678, 8'h01, 8'h00, 1, 16'h02F8};
        vecs[4] = '{32'h1234_5678, 8'h00, 8'h80, 7, 16'h80FF};
        vecs[5] = '{32'h1234_5678, 8'h00, 8'h80, 6, 16'h40A4};
        vecs[6] = '{32'h0000_0050, 8'h00, 8'h00, 1, 16'h0292};
`ifdef SEG_HC595_LZB_EN
        vecs[7] = '{32'h0000_0050, 8'h00, 8'h00, 5, 16'h20FF};
`else
        vecs[7] = '{32'h0000_0050, 8'h00, 8'h00, 5, 16'h20C0};
`endif
        vecs[8] = '{32'h0000_0050, 8'h00, 8'h00, 0, 16'h01C0};
        vecs[9] = '{32'hFEDC_BA98, 8'h00, 8'h00, 7, 16'h808E};

        // Reset state.
        repeat (4) @(negedge Clk);
        check("reset_dio", 32'(DIO), 32'd0);
        check("reset_srclk", 32'(SRCLK), 32'd0);
        check("reset_rclk", 32'(RCLK), 32'd0);
        check("reset_frame_done", 32'(Frame_Done), 32'd0);
        Reset_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            do_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
            get_frame(base);
            check($sformatf("vec%0d_digit%0d", i, vecs[i].digit),
                  32'(lat_q[base + vecs[i].digit]), 32'(vecs[i].exp));
        end

        // Randomized loads against the model.
        for (int r = 0; r < 6; r++) begin
            rd  = $urandom >> (4 * $urandom_range(0, 7));
            rdp = 8'($urandom_range(0, 255));
            rbl = 8'($urandom & $urandom & $urandom);
            do_load(rd, rdp, rbl);
            get_frame(base);
            check_frame($sformatf("rand%0d", r), base, rd, rdp, rbl, 0);
        end

        // Load during digit 3: rest of the current frame keeps old data.
        do_load(32'h1234_5678, 8'h00, 8'h00);
        get_frame(base);
        base = lat_q.size();
        wait_lat(base + 3, ok);
        check("mid_wait_digit2", 32'(ok), 32'd1);
        for (int i = 0; i < 200 && !SRCLK; i++) @(negedge Clk);
        do_load(32'h0BAD_CAFE, 8'h10, 8'h02);
        wait_fd(ok);
        check("mid_fd_wait", 32'(ok), 32'd1);
        check_frame("mid_old", base, 32'h1234_5678, 8'h00, 8'h00, 3);
        get_frame(base);
        check_frame("mid_new", base - 8, 32'h0BAD_CAFE, 8'h10, 8'h02, 0);
        check_frame("mid_next", base, 32'h0BAD_CAFE, 8'h10, 8'h02, 0);

        // Reset during SHIFT_HI of digit 2.
        base = lat_q.size();
        wait_lat(base + 2, ok);
        check("rst_wait_digit1", 32'(ok), 32'd1);
        for (int i = 0; i < 200 && !SRCLK; i++) @(negedge Clk);
        check("rst_srclk_high", 32'(SRCLK), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("rst_dio", 32'(DIO), 32'd0);
        check("rst_srclk", 32'(SRCLK), 32'd0);
        check("rst_rclk", 32'(RCLK), 32'd0);
        pre = lat_total;
        repeat (20) @(negedge Clk);
        check("rst_no_latch", 32'(lat_total), 32'(pre));
        check("rst_partial", 32'(lat_q.size() - base), 32'd2);
        Reset_n = 1'b1;
        base = lat_q.size();
        wait_lat(base + 1, ok);
        check("post_rst_wait", 32'(ok), 32'd1);
        check("post_rst_first", 32'(lat_q[base]), 32'h01C0);
        wait_fd(ok);
        check("post_rst_fd", 32'(ok), 32'd1);
        check_frame("post_rst", base, 32'h0, 8'h00, 8'h00, 0);

        // Pin-level rules accumulated over the whole run.
        check("protocol_viol", 32'(viol), 32'd0);
        check("frame_done_viol", 32'(fd_viol), 32'd0);
        check("latch_spacing", 32'(rclk_gap), 32'(TICK));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
